// File: rtl/oclib_uart_hex_parser.sv
// ASCII hex word parser for a UART byte stream: accumulates hex digits, emits a word on separator/terminator.
// Optional "0x"/"0X" prefix skipping is enabled by defining OCLIB_UART_HEX_PARSER_PREFIX_EN.
module oclib_uart_hex_parser #(
  parameter int DataWidth  = 32,
  parameter int ErrorWidth = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clearError,
  output logic [ErrorWidth-1:0] error,
  input  logic [7:0]            rxData,
  input  logic                  rxValid,
  output logic                  rxReady,
  output logic [DataWidth-1:0]  outData,
  output logic                  outTerm,
  output logic                  outValid,
  input  logic                  outReady
);

  localparam int NumDigits = DataWidth / 4;
  localparam int CntW      = $clog2(NumDigits + 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDiscard, StEmit} state_t;

  state_t                state, state_nx;
  logic [DataWidth-1:0]  acc, acc_nx, data_nx;
  logic [CntW-1:0]       cnt, cnt_nx;
  logic                  term_nx;
  logic [ErrorWidth-1:0] err_set;
  logic                  accept, is_digit, is_sep, is_term;
  logic [3:0]            nib;

  assign rxReady  = (state != StEmit);
  assign outValid = (state == StEmit);
  assign accept   = rxValid && rxReady;
  assign is_sep   = (rxData == 8'h20) || (rxData == 8'h09) || (rxData == 8'h2C);
  assign is_term  = (rxData == 8'h0D) || (rxData == 8'h0A);

  always_comb begin
    is_digit = 1'b0;
    nib      = 4'd0;
    if (rxData >= 8'h30 && rxData <= 8'h39) begin
      is_digit = 1'b1;
      nib      = rxData[3:0];
    end else if ((rxData >= 8'h41 && rxData <= 8'h46) || (rxData >= 8'h61 && rxData <= 8'h66)) begin
      is_digit = 1'b1;
      nib      = rxData[3:0] + 4'd9;
    end
  end

`ifdef OCLIB_UART_HEX_PARSER_PREFIX_EN
  logic pfx, pfx_nx, is_x;
  assign is_x = (rxData == 8'h78) || (rxData == 8'h58);
  always_ff @(posedge clock or negedge reset)
    if (!reset) pfx <= 1'b0;
    else        pfx <= pfx_nx;
`endif

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    data_nx  = outData;
    term_nx  = outTerm;
    err_set  = '0;
`ifdef OCLIB_UART_HEX_PARSER_PREFIX_EN
    pfx_nx   = pfx;
`endif
    case (state)
      StIdle: if (accept) begin
        if (is_digit) begin
          acc_nx   = DataWidth'(nib);
          cnt_nx   = CntW'(1);
          state_nx = StAccum;
`ifdef OCLIB_UART_HEX_PARSER_PREFIX_EN
          pfx_nx   = 1'b0;
`endif
        end else if (!(is_sep || is_term)) begin
          err_set[0] = 1'b1;
          state_nx   = StDiscard;
        end
      end
      StAccum: if (accept) begin
`ifdef OCLIB_UART_HEX_PARSER_PREFIX_EN
        // a lone leading '0' followed by x/X is a prefix, once per word
        if (is_x && !pfx && cnt == CntW'(1) && acc == '0) begin
          acc_nx = '0;
          cnt_nx = '0;
          pfx_nx = 1'b1;
        end else
`endif
        if (is_digit) begin
          acc_nx = (acc << 4) | DataWidth'(nib);
          if (cnt == CntW'(NumDigits)) err_set[1] = 1'b1;
          else                         cnt_nx     = cnt + CntW'(1);
        end else if (is_sep || is_term) begin
          data_nx  = acc;
          term_nx  = is_term;
          acc_nx   = '0;
          cnt_nx   = '0;
          state_nx = StEmit;
        end else begin
          err_set[0] = 1'b1;
          acc_nx     = '0;
          cnt_nx     = '0;
          state_nx   = StDiscard;
        end
      end
      StDiscard: if (accept && (is_sep || is_term)) state_nx = StIdle;
      StEmit:    if (outReady) state_nx = StIdle;
      default:   state_nx = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= StIdle;
      acc     <= '0;
      cnt     <= '0;
      outData <= '0;
      outTerm <= 1'b0;
      error   <= '0;
    end else begin
      state   <= state_nx;
      acc     <= acc_nx;
      cnt     <= cnt_nx;
      outData <= data_nx;
      outTerm <= term_nx;
      // a freshly detected error wins over a simultaneous clear
      error   <= (clearError ? '0 : error) | err_set;
    end
  end

endmodule
